// File: rtl/layer_seq_ctl_if.sv
// Sequencer control bundle: frame start request in, layer state and fmap tracking out.
interface layer_seq_ctl_if;
    logic       start;
    logic [3:0] state;
    logic [6:0] fmap_idx;
    logic [6:0] fmap_idx_delay4;
    logic       fmap_end;
    logic [2:0] res_blk;
    logic       busy;
    logic       done;

    modport master (
        output start,
        input  state, fmap_idx, fmap_idx_delay4, fmap_end, res_blk, busy, done
    );

    modport slave (
        input  start,
        output state, fmap_idx, fmap_idx_delay4, fmap_end, res_blk, busy, done
    );
endinterface

// File: rtl/layer_seq_ctl.sv
// Layer sequencer: walks PADDING, CONV1, RES pairs, UP_1, UP_2, CONV2 one pixel per cycle,
// never stalls, and closes each layer with a DELAY+1 cycle drain carrying the end marker.
module layer_seq_ctl #(
    parameter int W0         = 160,
    parameter int H0         = 90,
    parameter int C_MID      = 24,
    parameter int C_UP       = 96,
    parameter int NUM_RES    = 4,
    parameter int PAD_CYCLES = 16,
    parameter int DELAY      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    layer_seq_ctl_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PADDING = 4'd1,
        S_CONV1   = 4'd2,
        S_RES_1   = 4'd3,
        S_RES_2   = 4'd4,
        S_UP_1    = 4'd5,
        S_UP_2    = 4'd6,
        S_CONV2   = 4'd7,
        S_FINISH  = 4'd8
    } state_t;

    localparam logic [17:0] P_BASE     = 18'(W0 * H0);
    localparam logic [17:0] P_UP2      = 18'(4 * W0 * H0);
    localparam logic [17:0] P_CONV2    = 18'(16 * W0 * H0);
    localparam logic [6:0]  N_MID      = 7'(C_MID);
    localparam logic [6:0]  N_UP       = 7'(C_UP);
    localparam logic [15:0] PAD_LAST   = 16'(PAD_CYCLES - 1);
    localparam logic [7:0]  DRAIN_LAST = 8'(DELAY);
    localparam logic [2:0]  RES_LAST   = 3'(NUM_RES - 1);

    state_t      state_q, state_nxt;
    logic [15:0] pad_cnt_q, pad_cnt_nxt;
    logic [17:0] pix_q, pix_nxt;
    logic [6:0]  fidx_q, fidx_nxt;
    logic        fend_q, fend_nxt;
    logic        drain_q, drain_nxt;
    logic [7:0]  dcnt_q, dcnt_nxt;
    logic [2:0]  res_q, res_nxt;
    logic [6:0]  dly_q [DELAY];
    logic        layer_done;

    function automatic logic is_layer(state_t s);
        return (s == S_CONV1) || (s == S_RES_1) || (s == S_RES_2) ||
               (s == S_UP_1)  || (s == S_UP_2)  || (s == S_CONV2);
    endfunction

    function automatic logic [17:0] pix_total(state_t s);
        case (s)
            S_UP_2:  return P_UP2;
            S_CONV2: return P_CONV2;
            default: return P_BASE;
        endcase
    endfunction

    function automatic logic [6:0] fmap_total(state_t s);
        return ((s == S_UP_1) || (s == S_UP_2)) ? N_UP : N_MID;
    endfunction

    assign layer_done = drain_q && (dcnt_q == DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) state_nxt = S_PADDING;
            S_PADDING: if (pad_cnt_q == PAD_LAST) state_nxt = S_CONV1;
            S_CONV1:   if (layer_done) state_nxt = S_RES_1;
            S_RES_1:   if (layer_done) state_nxt = S_RES_2;
            S_RES_2:   if (layer_done) state_nxt = (res_q < RES_LAST) ? S_RES_1 : S_UP_1;
            S_UP_1:    if (layer_done) state_nxt = S_UP_2;
            S_UP_2:    if (layer_done) state_nxt = S_CONV2;
            S_CONV2:   if (layer_done) state_nxt = S_FINISH;
            S_FINISH:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Counter next values; fmap_end is registered by looking one pixel ahead.
    always_comb begin
        pad_cnt_nxt = (state_q == S_PADDING) ? pad_cnt_q + 16'd1 : 16'd0;
        pix_nxt     = 18'd0;
        fidx_nxt    = 7'd0;
        drain_nxt   = 1'b0;
        dcnt_nxt    = 8'd0;
        res_nxt     = res_q;
        if (is_layer(state_q)) begin
            if (drain_q) begin
                if (!layer_done) begin
                    drain_nxt = 1'b1;
                    dcnt_nxt  = dcnt_q + 8'd1;
                end
            end else if (fend_q) begin
                if (fidx_q == fmap_total(state_q) - 7'd1) begin
                    fidx_nxt  = fmap_total(state_q);
                    drain_nxt = 1'b1;
                end else begin
                    fidx_nxt = fidx_q + 7'd1;
                end
            end else begin
                pix_nxt  = pix_q + 18'd1;
                fidx_nxt = fidx_q;
            end
        end
        if ((state_q == S_RES_2) && layer_done)
            res_nxt = (res_q < RES_LAST) ? res_q + 3'd1 : 3'd0;
        if (state_q == S_IDLE)
            res_nxt = 3'd0;
        fend_nxt = is_layer(state_nxt) && !drain_nxt &&
                   (pix_nxt == pix_total(state_nxt) - 18'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_cnt_q <= '0;
            pix_q     <= '0;
            fidx_q    <= '0;
            fend_q    <= 1'b0;
            drain_q   <= 1'b0;
            dcnt_q    <= '0;
            res_q     <= '0;
            for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
        end else begin
            pad_cnt_q <= pad_cnt_nxt;
            pix_q     <= pix_nxt;
            fidx_q    <= fidx_nxt;
            fend_q    <= fend_nxt;
            drain_q   <= drain_nxt;
            dcnt_q    <= dcnt_nxt;
            res_q     <= res_nxt;
            dly_q[0]  <= fidx_q;
            for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    always_comb begin
        bus.state           = state_q;
        bus.fmap_idx        = fidx_q;
        bus.fmap_idx_delay4 = dly_q[DELAY-1];
        bus.fmap_end        = fend_q;
        bus.res_blk         = res_q;
        bus.busy            = (state_q != S_IDLE);
        bus.done            = (state_q == S_FINISH);
    end

endmodule

// File: doc/layer_seq_ctl.md
# layer_seq_ctl

Top-level layer sequencer for the super-resolution CNN accelerator. It steps the network through PADDING, CONV1, a configurable number of RES_1/RES_2 pairs, UP_1, UP_2 and CONV2. It generates the `state`, `fmap_idx`, `fmap_idx_delay4` and `fmap_end` signals consumed by the row/column address counter and the PE datapath. One output pixel is processed per cycle in every layer state, with no stalls.

## Interface
- `W0`, default 160: base-layer width (CONV1/RES/UP_1); UP_2 uses 2*W0, CONV2 uses 4*W0.
- `H0`, default 90: base-layer height; UP_2 uses 2*H0, CONV2 uses 4*H0.
- `C_MID`, default 24: fmaps per layer for CONV1, RES_1, RES_2 and CONV2.
- `C_UP`, default 96: fmaps per layer for UP_1 and UP_2.
- `NUM_RES`, default 4: number of RES_1/RES_2 pairs, minimum 1.
- `PAD_CYCLES`, default 16: cycles spent in PADDING.
- `DELAY`, default 4: depth of the `fmap_idx_delay4` pipeline.

- `clk` input 1: clock; all logic is posedge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: begin one frame; sampled only in IDLE.
- `state` output 4: IDLE=0, PADDING=1, CONV1=2, RES_1=3, RES_2=4, UP_1=5, UP_2=6, CONV2=7, FINISH=8.
- `fmap_idx` output 7: current output-fmap index; equals the layer's fmap count for one cycle as the layer-end marker.
- `fmap_idx_delay4` output 7: `fmap_idx` delayed by DELAY cycles.
- `fmap_end` output 1: high in the cycle processing the last pixel of a fmap.
- `res_blk` output 3: index of the current residual pair, 0..NUM_RES-1.
- `busy` output 1: `state != IDLE`.
- `done` output 1: one-cycle pulse in FINISH.

## Operation
- **Reset values:** all outputs are 0, the delay pipe is 0, and `state` is IDLE.
- **IDLE:** `start=1` moves to PADDING.
- **PADDING:** a counter runs for PAD_CYCLES cycles, then the block enters CONV1.
- **Layer states:** a pixel counter `pix_cnt` (18 bits) counts 0..P-1, one step per cycle.
  - P = W0*H0 for CONV1, RES_1, RES_2 and UP_1.
  - P = 4*W0*H0 for UP_2.
  - P = 16*W0*H0 for CONV2.
- **`fmap_end`:** high when `pix_cnt == P-1`. It is driven from a flop, precomputed from `pix_cnt == P-2`, or from the first cycle when P=1.
- **After `fmap_end`:** `pix_cnt` returns to 0 and `fmap_idx` increments.
- **Layer end:** after `fmap_end` of fmap N-1 (N = the layer's fmap count):
  - The layer enters a drain of DELAY+1 cycles.
  - In the first drain cycle `fmap_idx = N`; in the remaining DELAY drain cycles `fmap_idx = 0`.
  - `pix_cnt` is held at 0 and `fmap_end` stays 0 throughout the drain.
- **Layer order after the drain:**
  - CONV1 goes to RES_1, and RES_1 goes to RES_2.
  - RES_2 goes to RES_1 with `res_blk+1` if `res_blk < NUM_RES-1`. Otherwise it goes to UP_1 and `res_blk` is cleared to 0.
  - UP_1 goes to UP_2, UP_2 goes to CONV2, and CONV2 goes to FINISH.
- **FINISH:** lasts one cycle with `done=1`, then returns to IDLE.
- **Ignored inputs:** `start` has no effect outside IDLE.
- **Reset mid-frame:** the next cycle shows IDLE with all counters and the delay pipe at 0.

## Timing
- `start` high in IDLE at cycle t:
  - `state = PADDING` from t+1 through t+PAD_CYCLES.
  - `state = CONV1` at t+PAD_CYCLES+1, with `pix_cnt = 0` and `fmap_idx = 0`.
- Each fmap lasts exactly P cycles; `fmap_idx` steps in the cycle after `fmap_end`.
- Last `fmap_end` of a layer at cycle e:
  - `fmap_idx = N` at e+1.
  - `fmap_idx_delay4 = N` at exactly e+1+DELAY, for one cycle only.
  - The next layer starts at e+2+DELAY.
- Because `fmap_idx_delay4 = N` lasts a single cycle, the downstream row/col counter sees its layer-transfer reset once and starts the new layer at col 0, row 0.
- Total cycles in a layer = N*P + DELAY + 1.
- `fmap_idx_delay4` shifts every cycle in all states, including IDLE.

## Test plan
Unless stated otherwise, the bench uses `W0=4`, `H0=2`, `C_MID=2`, `C_UP=3`, `NUM_RES=2`, `PAD_CYCLES=3`.

- **Reset then idle:** reset, hold `start=0` for 20 cycles -> `state=0`, all outputs 0, `busy=0`.
- **Start and padding:** pulse `start` at cycle 10 -> PADDING in cycles 11–13, CONV1 at 14, first `fmap_end` at 21, `fmap_idx=1` at 22.
- **CONV1 layer end:**
  - Checks: `fmap_idx=2` at 30, `fmap_idx_delay4=2` only at 34, RES_1 begins at 35.
  - Protocol checker: `fmap_end` is never high during the drain.
- **Full frame:**
  - Run one frame: `res_blk` goes 0,0,1,1 across RES_1/RES_2/RES_1/RES_2.
  - Layer lengths: UP_2 = 3*32+5 cycles, CONV2 = 2*128+5 cycles.
  - End of frame: `done` pulses once, then `state=0`.
- **Ignored start:** toggle `start` during CONV1 and UP_1 -> no change versus the reference trace.
- **Reset mid-frame:** assert `rst_n=0` during UP_2 -> IDLE next cycle with all outputs 0. A subsequent `start` replays the frame identically.
